// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter merging pipeline W-stage writes with a buffered mult/div result FIFO.
// Define WB_ARB_STATUS_EN to redirect mult/div error results to rstatus (r30).
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    input  logic        md_error,
    output logic        md_ready,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic [31:0] busy_mask,
    output logic        stall_req
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [4:0]    reg_q  [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW:0]   wptr_q, rptr_q, occ;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d, stall_q;
    logic [4:0]    wreg_q, wreg_d, hreg;
    logic [31:0]   wdata_q, wdata_d, hdata;
    logic          empty, full, push, pop, slot_a;
    logic [AW-1:0] widx, ridx;

    assign widx   = wptr_q[AW-1:0];
    assign ridx   = rptr_q[AW-1:0];
    assign occ    = wptr_q - rptr_q;
    assign empty  = wptr_q == rptr_q;
    assign full   = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
    assign push   = md_valid & ~full;
    assign slot_a = wb_valid & (wb_reg != 5'd0);
    assign pop    = ~slot_a & ~empty;

`ifdef WB_ARB_STATUS_EN
    logic err_q [DEPTH];
    assign hreg  = err_q[ridx] ? 5'd30 : reg_q[ridx];
    assign hdata = err_q[ridx] ? 32'd1 : data_q[ridx];
`else
    logic unused_md_error;
    assign unused_md_error = md_error;
    assign hreg  = reg_q[ridx];
    assign hdata = data_q[ridx];
`endif

    always_comb begin
        we_d    = slot_a | (pop & (hreg != 5'd0));
        wreg_d  = slot_a ? wb_reg : hreg;
        wdata_d = slot_a ? wb_data : hdata;
        cnt_d   = (empty | pop) ? '0 : (cnt_q == LIM ? cnt_q : cnt_q + 1'b1);
    end

    // Walk entries from the head so only live slots contribute to the mask.
    always_comb begin
        busy_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((AW+1)'(k) < occ) begin
                busy_mask[reg_q[ridx + AW'(k)]] = 1'b1;
`ifdef WB_ARB_STATUS_EN
                if (err_q[ridx + AW'(k)]) busy_mask[30] = 1'b1;
`endif
            end
        end
        busy_mask[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (push) begin
                reg_q[widx]  <= md_reg;
                data_q[widx] <= md_data;
`ifdef WB_ARB_STATUS_EN
                err_q[widx]  <= md_error;
`endif
                wptr_q       <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            cnt_q   <= cnt_d;
            stall_q <= cnt_d >= LIM;
            we_q    <= we_d;
            if (we_d) begin
                wreg_q  <= wreg_d;
                wdata_q <= wdata_d;
            end
        end
    end

    assign md_ready         = ~full;
    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;
    assign stall_req        = stall_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;
    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_reg = '0;
    logic [31:0] md_data = '0;
    logic        md_error = 1'b0;
    logic        md_ready, ctrl_writeEnable, stall_req;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg, busy_mask;
    int checks = 0;
    int errors = 0;

    wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_error(md_error),
        .md_ready(md_ready), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .busy_mask(busy_mask), .stall_req(stall_req)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
        check({tag, "_we"}, 32'(ctrl_writeEnable), 32'(we));
        check({tag, "_reg"}, 32'(ctrl_writeReg), 32'(r));
        check({tag, "_data"}, data_writeReg, d);
    endtask

    initial begin
        tick();
        tick();
        ctrl_reset = 1'b0;
        check_wr("reset", 1'b0, 5'd0, 32'd0);
        check("reset_ready", 32'(md_ready), 32'd1);
        check("reset_busy", busy_mask, 32'd0);
        check("reset_stall", 32'(stall_req), 32'd0);

        wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        check_wr("pipe_r5", 1'b1, 5'd5, 32'hDEADBEEF);
        wb_reg = 5'd0; wb_data = 32'h12345678;
        tick();
        check_wr("pipe_r0", 1'b0, 5'd5, 32'hDEADBEEF);
        wb_valid = 1'b0;

        md_valid = 1'b1; md_reg = 5'd7; md_data = 32'd42;
        tick();
        md_valid = 1'b0;
        check("md_busy_n1", busy_mask, 32'h80);
        check("md_we_n1", 32'(ctrl_writeEnable), 32'd0);
        tick();
        check_wr("md_n2", 1'b1, 5'd7, 32'd42);
        check("md_busy_n2", busy_mask, 32'd0);

        wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'd1;
        for (int i = 0; i < 4; i++) begin
            md_valid = 1'b1; md_reg = 5'(10 + i); md_data = 32'(100 + i);
            tick();
            if (i == 2) check("full_ready_3", 32'(md_ready), 32'd1);
        end
        check("full_ready_4", 32'(md_ready), 32'd0);
        check("full_busy", busy_mask, 32'h3C00);
        check_wr("full_pipe", 1'b1, 5'd3, 32'd1);
        md_reg = 5'd20; md_data = 32'd200;
        tick();
        check("held_ready", 32'(md_ready), 32'd0);
        check("held_busy", busy_mask, 32'h3C00);
        wb_valid = 1'b0;
        tick();
        md_valid = 1'b0;
        check_wr("drain0", 1'b1, 5'd10, 32'd100);
        check("drain0_ready", 32'(md_ready), 32'd1);
        check("drain0_busy", busy_mask, 32'h3800);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_wr("drain", 1'b1, 5'(10 + i), 32'(100 + i));
        end
        check("drain_busy_end", busy_mask, 32'd0);
        tick();
        check("drain_idle_we", 32'(ctrl_writeEnable), 32'd0);

        md_valid = 1'b1; md_reg = 5'd0; md_data = 32'd99;
        tick();
        md_valid = 1'b0;
        check("r0_busy", busy_mask, 32'd0);
        tick();
        check_wr("r0_pop", 1'b0, 5'd13, 32'd103);
        check("r0_empty_ready", 32'(md_ready), 32'd1);

        wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'd55;
        md_valid = 1'b1; md_reg = 5'd8; md_data = 32'd77;
        tick();
        md_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) check("starve_7", 32'(stall_req), 32'd0);
        end
        check("starve_8", 32'(stall_req), 32'd1);
        check("starve_busy", busy_mask, 32'h100);
        check_wr("starve_pipe", 1'b1, 5'd4, 32'd55);
        tick();
        check("starve_sat", 32'(stall_req), 32'd1);
        wb_valid = 1'b0;
        tick();
        check_wr("starve_pop", 1'b1, 5'd8, 32'd77);
        check("starve_clear", 32'(stall_req), 32'd0);

        wb_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            md_valid = 1'b1; md_reg = 5'(15 + i); md_data = 32'(150 + i);
            tick();
        end
        md_valid = 1'b0;
        check("rst_busy_pre", busy_mask, 32'h38000);
        wb_valid = 1'b0;
        ctrl_reset = 1'b1;
        tick();
        ctrl_reset = 1'b0;
        check_wr("rst_mid", 1'b0, 5'd0, 32'd0);
        check("rst_mid_busy", busy_mask, 32'd0);
        check("rst_mid_ready", 32'(md_ready), 32'd1);
        tick();
        check("rst_post1_we", 32'(ctrl_writeEnable), 32'd0);
        tick();
        check("rst_post2_we", 32'(ctrl_writeEnable), 32'd0);

        md_valid = 1'b1; md_reg = 5'd9; md_data = 32'd5; md_error = 1'b1;
        tick();
        md_valid = 1'b0; md_error = 1'b0;
`ifdef WB_ARB_STATUS_EN
        check("err_busy", busy_mask, 32'h4000_0200);
        tick();
        check_wr("err_write", 1'b1, 5'd30, 32'd1);
`else
        check("err_busy", busy_mask, 32'h200);
        tick();
        check_wr("err_write", 1'b1, 5'd9, 32'd5);
`endif
        tick();
        check("final_busy", busy_mask, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-stage arbiter sitting directly upstream of the register file. It owns the regfile write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg).
- Merges two result sources: the in-order pipeline W stage, which can never be stalled, and the multi-cycle mult/div unit, whose results arrive at arbitrary times.
- Mult/div results are buffered in a small FIFO and drained into idle writeback slots.
- Exports a pending-register mask for the hazard unit and a stall request when mult/div results are being starved.

Parameters:
- DEPTH, 4, mult/div result FIFO entries; power of 2, >= 2.
- STARVE_LIMIT, 8, consecutive non-draining cycles (FIFO non-empty) before stall_req asserts; >= 1.

Ports:
- clock  input  1  system clock, all state on rising edge
- ctrl_reset  input  1  synchronous, active-high reset
- wb_valid  input  1  pipeline W stage carries a register write this cycle
- wb_reg  input  5  pipeline destination register
- wb_data  input  32  pipeline result
- md_valid  input  1  mult/div result offered
- md_reg  input  5  mult/div destination register
- md_data  input  32  mult/div result
- md_error  input  1  mult/div exception (overflow / divide-by-zero) with this result
- md_ready  output  1  FIFO can accept; transfer occurs when md_valid & md_ready
- ctrl_writeEnable  output  1  regfile write enable (registered)
- ctrl_writeReg  output  5  regfile write address (registered)
- data_writeReg  output  32  regfile write data (registered)
- busy_mask  output  32  bit r = 1 if any FIFO entry targets register r
- stall_req  output  1  request pipeline to inject a W-stage bubble (registered)

Behaviour:
- Reset (ctrl_reset=1 at a rising edge): FIFO emptied, starve counter cleared. Outputs: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, stall_req=0. busy_mask=0 and md_ready=1 from the following cycle. Reset mid-drain discards all buffered results with no regfile write.
- Register 0 filtering: wb_valid with wb_reg==0 is treated as an idle slot. An accepted md entry with md_reg==0 is popped with ctrl_writeEnable=0 (no write). busy_mask[0] is always 0.
- md_ready = !full, from registered occupancy only. No push while full, even if a pop happens the same cycle.
- Push when md_valid & md_ready; entry stores {reg, data, error}.
- Arbitration each cycle, two-way, decided combinationally, result registered to the outputs at the next edge:
  - Slot A: wb_valid & wb_reg!=0 → pipeline write, FIFO untouched.
  - Slot B: otherwise, if FIFO non-empty → pop head, write head entry.
  - Otherwise ctrl_writeEnable=0. ctrl_writeReg and data_writeReg hold their previous values.
- Simultaneous push and pop in one cycle is legal; occupancy is unchanged.
- Pipeline write latency: 1 cycle (W-stage inputs at cycle N appear on regfile outputs in cycle N+1).
- Mult/div latency: minimum 2 cycles (push at N, pop decision at N+1, outputs valid at N+2). There is no push-to-output bypass.
- Ordering: FIFO is strictly in order. No reordering against pipeline writes. The hazard unit must use busy_mask to prevent pipeline writes or reads of pending registers (WAW/RAW). The arbiter does not check this.
- busy_mask is combinational from valid FIFO entries only, excluding the output register stage.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs; saturates at STARVE_LIMIT.
  - Clears on any pop or when the FIFO is empty.
  - stall_req is registered and equals (counter >= STARVE_LIMIT).
- Pipeline contract: when stall_req=1, the pipeline drives wb_valid=0 in the same cycle. If wb_valid=1 arrives anyway, the pipeline still wins, and stall_req stays high.
- Wrap-around: read/write pointers carry one extra bit. full when pointers differ only in the MSB; empty when equal.

Optional Feature:
- Macro: WB_ARB_STATUS_EN.
- Defined: a popped entry with error=1 writes register 30 (rstatus) with data = {31'b0, 1'b1} instead of its own reg/data. busy_mask additionally sets bit 30 for any buffered error entry.
- Undefined: md_error is ignored (not stored), and entries always write their own reg/data.

Test Plan:
- Reset then idle: ctrl_reset=1 for 2 cycles → all outputs 0, md_ready=1, busy_mask=0, stall_req=0.
- Pipeline write: wb_valid=1, wb_reg=5, wb_data=0xDEADBEEF at cycle N → cycle N+1: ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF. Same stimulus with wb_reg=0 → ctrl_writeEnable=0.
- Mult/div drain, pipeline idle: md push reg=7, data=42 at N → busy_mask=0x80 at N+1 → write reg 7 = 42 at N+2 → busy_mask=0.
- FIFO full and back-pressure (DEPTH=4): wb_valid=1 every cycle with 4 md pushes → md_ready=0 after the 4th push, the 5th offer is held. Then drop wb_valid → 4 writes in push order on consecutive cycles, md_ready=1 after the first pop.
- Starvation: 1 entry buffered, wb_valid=1 to nonzero regs continuously → stall_req=1 after 8 non-pop cycles. Then wb_valid=0 → pop next cycle, stall_req=0 one cycle after the pop.
- Reset mid-drain plus WB_ARB_STATUS_EN: 3 entries buffered, assert ctrl_reset → no further writes, busy_mask=0. With the macro defined, push error=1 reg=9 → write reg 30 = 1, no write to reg 9.
